pcm_nrz_tx: RTL and testbench
=============================

Name: pcm_nrz_tx

Overview:
- Serial PCM NRZ telemetry generator: the transmit-side counterpart of the PCM NRZ frame decoder.
- Accepts bytes over a valid/ready stream and buffers them in a small FIFO.
- Emits continuous fixed-length frames at a parameterised bit rate: 32-bit sync pattern, then data words, MSB first.
- Used as a bench/loopback stimulus source for the decoder cores: drives the decoder's rxd at 51.2 kbps HBR or 1.6 kbps LBR.

Parameters:
- CLK_HZ, 10240000, input clock frequency.
- BIT_RATE, 51200, serial bit rate; CLKS_PER_BIT = CLK_HZ/BIT_RATE (integer; elaboration error if not exact).
- FRAME_SIZE, 128, words per frame including the 4 sync words; must be ≥ 5.
- SYNC_WORD, 32'hF9E8_B38C, sync pattern sent in words 0-3, MSB first.
- FILL_BYTE, 8'h00, byte sent when the FIFO is empty at a data-word boundary.
- FIFO_DEPTH, 16, input buffer depth; power of 2, ≥ 2.

Ports:
- clk  in  1  system clock (10.24 MHz PCM clock)
- rst  in  1  synchronous active-high reset
- en  in  1  run request; sampled every cycle
- s_data  in  8  input byte
- s_valid  in  1  s_data valid
- s_ready  out  1  FIFO can accept; a transfer occurs when s_valid & s_ready
- txd  out  1  NRZ serial output
- bit_tick  out  1  one-cycle pulse in the first cycle of each transmitted bit
- frame_start  out  1  one-cycle pulse coincident with bit_tick of frame bit 0
- underrun  out  1  one-cycle pulse when FILL_BYTE is substituted
- busy  out  1  high in SYNC or DATA state

Behaviour:
- Reset (rst high at a clk edge): state IDLE, bit counter 0, FIFO emptied.
  - All outputs registered, reset value 0.
  - s_ready = 0 while rst is high, then !full; it is 1 on the first cycle after reset release.
- FIFO:
  - Write on s_valid & s_ready.
  - Read only at data-word load points.
  - Simultaneous write and read when full is not possible, because s_ready = 0.
  - Simultaneous write and read when empty: the read sees empty, so FILL_BYTE is used and the written byte remains stored.
  - Occupancy counter width is $clog2(FIFO_DEPTH)+1.
- State machine:
  - IDLE: txd = 0, busy = 0. On en = 1, go to SYNC on the next edge, loading shift register = SYNC_WORD, bit index 0, word index 0.
  - SYNC: shift out 32 bits, MSB first. After bit 31 completes, go to DATA (word index 4).
  - DATA: at the start of each word, pop the FIFO into an 8-bit shift register. If empty, load FILL_BYTE and pulse underrun in the same cycle as bit_tick. Shift out 8 bits, MSB first.
  - After the last bit of word FRAME_SIZE-1:
    - if en = 1, go directly to SYNC with no gap (back-to-back frames);
    - else go to IDLE, with txd = 0.
- en deasserted mid-frame: the current frame completes; it is never truncated.
- rst mid-frame: immediate return to IDLE on the next edge; the frame is abandoned.
- Timing:
  - Each bit is held for exactly CLKS_PER_BIT cycles.
  - The baud counter counts 0..CLKS_PER_BIT-1 and wraps.
  - bit_tick is asserted when the counter is 0 in SYNC/DATA.
  - Frame length is exactly FRAME_SIZE*8*CLKS_PER_BIT cycles.
- Latency: en sampled high in IDLE at edge N → txd = SYNC_WORD[31], bit_tick = 1 and frame_start = 1 in the cycle after edge N+1.
- Counter widths:
  - baud counter: $clog2(CLKS_PER_BIT);
  - word index: $clog2(FRAME_SIZE);
  - bit index: 5 bits.

Decomposition:
- Package pcm_pkg:
  - PCM_SYNC_WORD constant;
  - HBR/LBR rate and frame-size constants (51200/128, 1600/200);
  - state enum {IDLE, SYNC, DATA};
  - clks_per_bit function.
- One sub-module: pcm_tx_fifo, a synchronous FIFO with parameter DEPTH, width 8, full/empty/count outputs, and the same clk/rst.

Test Plan (CLK_HZ=8, BIT_RATE=1 → 8 clks/bit, FRAME_SIZE=6, FIFO_DEPTH=4):
- Basic frame: push 8'hA5, 8'h3C, then en = 1 → txd carries SYNC_WORD MSB-first, then 10100101, then 00111100.
  - Each bit lasts 8 cycles.
  - frame_start pulses once; underrun stays 0.
- Underrun: en = 1 with an empty FIFO → words 4 and 5 are 8'h00; underrun pulses twice, coincident with those words' first bit_tick.
- Back-to-back frames: hold en = 1 for 3 frames → frame_start pulses are exactly 384 cycles apart, with no idle gap.
- Graceful stop: drop en at frame bit 10 → the frame runs to bit 47, then txd = 0 and busy = 0 one cycle after the last bit period.
- Backpressure: push 5 bytes while IDLE → s_ready falls after the 4th byte; the 5th is held until the first data-word pop, then accepted. Byte order is preserved.
- Reset mid-frame: assert rst during word 4 → the next cycle has all outputs 0 and FIFO empty; s_ready = 1 one cycle after rst falls.

Source files
------------

// File: rtl/pcm_nrz_tx_pkg.sv
// Shared constants, state encoding and rate helper for the PCM NRZ
// telemetry cores (transmitter and decoder).
package pcm_pkg;

   // Frame sync pattern, sent MSB first in frame words 0-3
   localparam logic [31:0] PCM_SYNC_WORD = 32'hF9E8_B38C;

   // Nominal PCM system clock
   localparam int PCM_CLK_HZ = 10240000;

   // High bit rate telemetry format
   localparam int HBR_BIT_RATE   = 51200;
   localparam int HBR_FRAME_SIZE = 128;

   // Low bit rate telemetry format
   localparam int LBR_BIT_RATE   = 1600;
   localparam int LBR_FRAME_SIZE = 200;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SYNC = 2'd1,
      DATA = 2'd2
   } pcm_state_e;

   // Clock cycles per serial bit; callers check that the division is exact
   function automatic int clks_per_bit(input int clk_hz, input int bit_rate);
      return clk_hz / bit_rate;
   endfunction

endpackage

// File: rtl/pcm_nrz_tx_if.sv
// Byte stream into the PCM transmitter: valid/ready handshake.
interface pcm_nrz_tx_if;
   logic [7:0] s_data;
   logic       s_valid;
   logic       s_ready;

   modport master (output s_data, output s_valid, input  s_ready);
   modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

// File: rtl/pcm_tx_fifo.sv
// Byte FIFO with show-ahead read data. Reads and writes are ignored when
// the FIFO is empty or full respectively, so callers may request freely.
module pcm_tx_fifo #(
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_i,
   input  logic [7:0]    wdata_i,
   input  logic          rd_i,
   output logic [7:0]    rdata_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o,
   output logic          full_nxt_o
);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("pcm_tx_fifo: DEPTH must be a power of 2 and at least 2");
   end

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          wr_ok, rd_ok;

   assign full_o     = (cnt_q == CW'(DEPTH));
   assign empty_o    = (cnt_q == '0);
   assign count_o    = cnt_q;
   assign rdata_o    = mem_q[rptr_q];
   assign wr_ok      = wr_i & ~full_o;
   // An empty FIFO never serves a read, even if a write lands the same cycle
   assign rd_ok      = rd_i & ~empty_o;
   assign full_nxt_o = (cnt_d == CW'(DEPTH));

   // Occupancy for the next cycle
   always_comb begin
      cnt_d = cnt_q;
      if (wr_ok && !rd_ok)      cnt_d = cnt_q + CW'(1);
      else if (rd_ok && !wr_ok) cnt_d = cnt_q - CW'(1);
   end

   // Storage array; contents need no reset, pointers define validity
   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wptr_q] <= wdata_i;
   end

   // Pointers and occupancy; pointers wrap naturally at power-of-2 depth
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (wr_ok) wptr_q <= wptr_q + AW'(1);
         if (rd_ok) rptr_q <= rptr_q + AW'(1);
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/pcm_nrz_tx.sv
// PCM NRZ telemetry transmitter. Bytes arrive on a valid/ready stream into
// a small FIFO; frames of FRAME_SIZE words (4 sync words, then data bytes)
// are shifted out MSB first, each bit held CLKS_PER_BIT clocks. All serial
// outputs are registered, so they trail the internal state by one cycle.
module pcm_nrz_tx
   import pcm_pkg::*;
#(
   parameter int          CLK_HZ     = PCM_CLK_HZ,
   parameter int          BIT_RATE   = HBR_BIT_RATE,
   parameter int          FRAME_SIZE = HBR_FRAME_SIZE,
   parameter logic [31:0] SYNC_WORD  = PCM_SYNC_WORD,
   parameter logic [7:0]  FILL_BYTE  = 8'h00,
   parameter int          FIFO_DEPTH = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   pcm_nrz_tx_if.slave  s,
   output logic         txd,
   output logic         bit_tick,
   output logic         frame_start,
   output logic         underrun,
   output logic         busy
);

   localparam int CPB = clks_per_bit(CLK_HZ, BIT_RATE);
   localparam int BW  = (CPB > 1) ? $clog2(CPB) : 1;
   localparam int WW  = $clog2(FRAME_SIZE);
   localparam int CW  = $clog2(FIFO_DEPTH) + 1;

   if (CLK_HZ % BIT_RATE != 0) begin : g_bad_rate
      $error("pcm_nrz_tx: CLK_HZ must be an exact multiple of BIT_RATE");
   end
   if (FRAME_SIZE < 5) begin : g_bad_frame
      $error("pcm_nrz_tx: FRAME_SIZE must be at least 5");
   end

   pcm_state_e    state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [4:0]    bit_q, bit_d;
   logic [WW-1:0] word_q, word_d;
   logic [31:0]   shreg_q, shreg_d;

   logic txd_q, txd_d;
   logic tick_q, tick_d;
   logic fstart_q, fstart_d;
   logic urun_q, urun_d;
   logic busy_q;
   logic s_ready_q;

   logic          pop;
   logic [7:0]    byte_v;
   logic [7:0]    fifo_rdata;
   logic          fifo_empty;
   logic          fifo_full_nxt;
   logic          fifo_full_unused;
   logic [CW-1:0] fifo_cnt_unused;

   assign s.s_ready   = s_ready_q;
   assign txd         = txd_q;
   assign bit_tick    = tick_q;
   assign frame_start = fstart_q;
   assign underrun    = urun_q;
   assign busy        = busy_q;

   pcm_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .wr_i       (s.s_valid & s_ready_q),
      .wdata_i    (s.s_data),
      .rd_i       (pop),
      .rdata_o    (fifo_rdata),
      .full_o     (fifo_full_unused),
      .empty_o    (fifo_empty),
      .count_o    (fifo_cnt_unused),
      .full_nxt_o (fifo_full_nxt)
   );

   // Frame sequencer: baud/bit/word counters, shift register and the
   // values the output registers will take on the next edge
   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      word_d   = word_q;
      shreg_d  = shreg_q;
      txd_d    = txd_q;
      tick_d   = 1'b0;
      fstart_d = 1'b0;
      urun_d   = 1'b0;
      pop      = 1'b0;
      byte_v   = FILL_BYTE;

      case (state_q)
         SYNC, DATA: begin
            // First clock of a bit period
            if (baud_q == '0) begin
               tick_d   = 1'b1;
               fstart_d = (state_q == SYNC) && (bit_q == 5'd0);
               // Data words are fetched right as their first bit starts so
               // the underrun pulse lines up with that bit's tick
               if (state_q == DATA && bit_q == 5'd0) begin
                  pop     = !fifo_empty;
                  byte_v  = fifo_empty ? FILL_BYTE : fifo_rdata;
                  urun_d  = fifo_empty;
                  shreg_d = {byte_v, 24'h0};
               end
               txd_d = shreg_d[31];
            end

            // Last clock of a bit period: advance to the next bit
            if (baud_q == BW'(CPB - 1)) begin
               baud_d  = '0;
               shreg_d = {shreg_d[30:0], 1'b0};
               bit_d   = bit_q + 5'd1;
               if (state_q == SYNC) begin
                  if (bit_q == 5'd31) begin
                     state_d = DATA;
                     bit_d   = 5'd0;
                     word_d  = WW'(4);
                  end
               end else if (bit_q == 5'd7) begin
                  bit_d = 5'd0;
                  if (word_q == WW'(FRAME_SIZE - 1)) begin
                     // Frame boundary is the only place en is honoured
                     word_d = '0;
                     if (en) begin
                        state_d = SYNC;
                        shreg_d = SYNC_WORD;
                     end else begin
                        state_d = IDLE;
                     end
                  end else begin
                     word_d = word_q + WW'(1);
                  end
               end
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end

         default: begin
            txd_d  = 1'b0;
            baud_d = '0;
            bit_d  = 5'd0;
            word_d = '0;
            if (en) begin
               state_d = SYNC;
               shreg_d = SYNC_WORD;
            end
         end
      endcase
   end

   // Sequencer state and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         baud_q    <= '0;
         bit_q     <= 5'd0;
         word_q    <= '0;
         shreg_q   <= '0;
         txd_q     <= 1'b0;
         tick_q    <= 1'b0;
         fstart_q  <= 1'b0;
         urun_q    <= 1'b0;
         busy_q    <= 1'b0;
         s_ready_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_q     <= bit_d;
         word_q    <= word_d;
         shreg_q   <= shreg_d;
         txd_q     <= txd_d;
         tick_q    <= tick_d;
         fstart_q  <= fstart_d;
         urun_q    <= urun_d;
         busy_q    <= (state_q != IDLE);
         s_ready_q <= !fifo_full_nxt;
      end
   end

endmodule

// File: tb/tb_pcm_nrz_tx.sv
// Bench for pcm_nrz_tx: 8 clocks per bit, 6-word frames, 4-deep FIFO.
// Expected serial bits are queued as stimulus is chosen and consumed as
// the DUT transmits them.
module tb_pcm_nrz_tx;

   localparam int          CPB    = 8;
   localparam int          FBITS  = 48;
   localparam int          FCYC   = FBITS * CPB;
   localparam logic [31:0] SYNC_W = 32'hF9E8_B38C;

   logic clk = 1'b0;
   logic rst, en;
   logic txd, bit_tick, frame_start, underrun, busy;

   int n_checks = 0;
   int n_fail   = 0;

   bit exp_bits[$];
   bit exp_ur[$];

   pcm_nrz_tx_if sif ();

   pcm_nrz_tx #(
      .CLK_HZ    (8),
      .BIT_RATE  (1),
      .FRAME_SIZE(6),
      .SYNC_WORD (32'hF9E8_B38C),
      .FILL_BYTE (8'h00),
      .FIFO_DEPTH(4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .s          (sif),
      .txd        (txd),
      .bit_tick   (bit_tick),
      .frame_start(frame_start),
      .underrun   (underrun),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic push_frame(input logic [7:0] w4, input logic [7:0] w5,
                             input bit u4, input bit u5);
      for (int i = 31; i >= 0; i--) begin
         exp_bits.push_back(SYNC_W[i]);
         exp_ur.push_back(1'b0);
      end
      for (int i = 7; i >= 0; i--) begin
         exp_bits.push_back(w4[i]);
         exp_ur.push_back((i == 7) ? u4 : 1'b0);
      end
      for (int i = 7; i >= 0; i--) begin
         exp_bits.push_back(w5[i]);
         exp_ur.push_back((i == 7) ? u5 : 1'b0);
      end
   endtask

   // Called at a negedge; holds the byte until it is accepted
   task automatic push_byte(input logic [7:0] b);
      int k = 0;
      sif.s_data  = b;
      sif.s_valid = 1'b1;
      while (sif.s_ready !== 1'b1 && k < 2000) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (sif.s_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL push_timeout: s_ready=%b required 1", sif.s_ready);
      end
      @(negedge clk);
      sif.s_valid = 1'b0;
   endtask

   // Waits for frame_start, then checks every cycle of one frame against
   // the expected queue. Drops en at frame cycle stop_at (if >= 0).
   // Returns at the first cycle after the frame.
   task automatic drain_frame(input int stop_at, output int waited);
      int k = 0;
      bit e = 1'b0;
      bit u = 1'b0;
      while (frame_start !== 1'b1 && k < 1000) begin
         @(negedge clk);
         k++;
      end
      waited = k;
      n_checks++;
      if (frame_start !== 1'b1) begin
         n_fail++;
         $display("FAIL frame_start_timeout: frame_start=%b required 1", frame_start);
         return;
      end
      for (int cyc = 0; cyc < FCYC; cyc++) begin
         if (cyc % CPB == 0) begin
            n_checks++;
            if (exp_bits.size() == 0) begin
               n_fail++;
               $display("FAIL scoreboard_empty: cycle %0d", cyc);
            end else begin
               e = exp_bits.pop_front();
               u = exp_ur.pop_front();
            end
            n_checks++;
            if (bit_tick !== 1'b1 || txd !== e || busy !== 1'b1) begin
               n_fail++;
               $display("FAIL bit%0d_start: tick=%b txd=%b busy=%b required 1 %b 1",
                        cyc / CPB, bit_tick, txd, busy, e);
            end
            n_checks++;
            if (underrun !== u || frame_start !== (cyc == 0)) begin
               n_fail++;
               $display("FAIL bit%0d_flags: underrun=%b frame_start=%b required %b %b",
                        cyc / CPB, underrun, frame_start, u, (cyc == 0));
            end
         end else begin
            n_checks++;
            if (txd !== e || bit_tick !== 1'b0 || underrun !== 1'b0 ||
                frame_start !== 1'b0 || busy !== 1'b1) begin
               n_fail++;
               $display("FAIL bit%0d_hold: txd=%b tick=%b ur=%b fs=%b busy=%b required %b 0 0 0 1",
                        cyc / CPB, txd, bit_tick, underrun, frame_start, busy, e);
            end
         end
         if (cyc == stop_at) en = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic check_stopped(input string name);
      n_checks++;
      if (txd !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_stop: txd=%b busy=%b required 0 0", name, txd, busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      en  = 1'b0;
      sif.s_valid = 1'b0;
      sif.s_data  = 8'h00;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({txd, bit_tick, frame_start, underrun, busy} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: %b required 00000",
                  {txd, bit_tick, frame_start, underrun, busy});
      end
      n_checks++;
      if (sif.s_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_s_ready: %b required 0", sif.s_ready);
      end
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (sif.s_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: s_ready=%b busy=%b required 1 0", sif.s_ready, busy);
      end
   endtask

   task automatic test_basic_frame();
      int w;
      push_byte(8'hA5);
      push_byte(8'h3C);
      push_frame(8'hA5, 8'h3C, 1'b0, 1'b0);
      en = 1'b1;
      drain_frame(20, w);
      n_checks++;
      if (w != 2) begin
         n_fail++;
         $display("FAIL basic_latency: %0d cycles required 2", w);
      end
      check_stopped("basic");
   endtask

   task automatic test_underrun();
      int w;
      push_frame(8'h00, 8'h00, 1'b1, 1'b1);
      en = 1'b1;
      drain_frame(20, w);
      check_stopped("underrun");
   endtask

   task automatic test_back_to_back();
      int w;
      push_byte(8'h11);
      push_byte(8'h22);
      push_byte(8'h33);
      push_byte(8'h44);
      push_frame(8'h11, 8'h22, 1'b0, 1'b0);
      push_frame(8'h33, 8'h44, 1'b0, 1'b0);
      push_frame(8'h00, 8'h00, 1'b1, 1'b1);
      en = 1'b1;
      drain_frame(-1, w);
      for (int f = 1; f < 3; f++) begin
         drain_frame((f == 2) ? 10 : -1, w);
         n_checks++;
         if (w != 0) begin
            n_fail++;
            $display("FAIL b2b_gap%0d: %0d extra cycles required 0", f, w);
         end
      end
      check_stopped("b2b");
   endtask

   task automatic test_graceful_stop();
      int w;
      push_byte(8'h5A);
      push_byte(8'hC3);
      push_frame(8'h5A, 8'hC3, 1'b0, 1'b0);
      en = 1'b1;
      drain_frame(10 * CPB, w);
      check_stopped("graceful");
      for (int c = 0; c < 16; c++) begin
         n_checks++;
         if (busy !== 1'b0 || frame_start !== 1'b0 || txd !== 1'b0) begin
            n_fail++;
            $display("FAIL graceful_idle%0d: busy=%b fs=%b txd=%b required 0 0 0",
                     c, busy, frame_start, txd);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_backpressure();
      int w;
      push_byte(8'h01);
      push_byte(8'h02);
      push_byte(8'h03);
      push_byte(8'h04);
      n_checks++;
      if (sif.s_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_full: s_ready=%b required 0", sif.s_ready);
      end
      push_frame(8'h01, 8'h02, 1'b0, 1'b0);
      sif.s_data  = 8'h05;
      sif.s_valid = 1'b1;
      en = 1'b1;
      fork
         drain_frame(20, w);
         begin
            int k = 0;
            while (sif.s_ready !== 1'b1 && k < 2000) begin
               @(negedge clk);
               k++;
            end
            n_checks++;
            if (k != 2 + 32 * CPB) begin
               n_fail++;
               $display("FAIL bp_accept_time: %0d cycles required %0d", k, 2 + 32 * CPB);
            end
            @(negedge clk);
            sif.s_valid = 1'b0;
         end
      join
      check_stopped("bp1");
      push_frame(8'h03, 8'h04, 1'b0, 1'b0);
      en = 1'b1;
      drain_frame(20, w);
      push_frame(8'h05, 8'h00, 1'b0, 1'b1);
      en = 1'b1;
      drain_frame(20, w);
      check_stopped("bp3");
   endtask

   task automatic test_reset_mid_frame();
      int k = 0;
      int w;
      push_byte(8'h77);
      push_byte(8'h88);
      en = 1'b1;
      while (frame_start !== 1'b1 && k < 1000) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (frame_start !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_start: frame_start=%b required 1", frame_start);
      end
      repeat (32 * CPB + 4) @(negedge clk);
      rst = 1'b1;
      en  = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({txd, bit_tick, frame_start, underrun, busy, sif.s_ready} !== 6'b0) begin
         n_fail++;
         $display("FAIL rstmid_outputs: %b required 000000",
                  {txd, bit_tick, frame_start, underrun, busy, sif.s_ready});
      end
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (sif.s_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_s_ready: %b required 1", sif.s_ready);
      end
      // The unsent byte 8'h88 must have been discarded
      push_frame(8'h00, 8'h00, 1'b1, 1'b1);
      en = 1'b1;
      drain_frame(20, w);
      check_stopped("rstmid");
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_underrun();
      test_back_to_back();
      test_graceful_stop();
      test_backpressure();
      test_reset_mid_frame();
      n_checks++;
      if (exp_bits.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_leftover: %0d bits remain required 0", exp_bits.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
